// File: rtl/ram_pkg.sv
// Shared types and default sizes for the dual-port clearable RAM.
package ram_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 3;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } ram_state_t;

endpackage

// File: rtl/ram_dp_core.sv
// Bare storage array: one write port, one registered read port, no reset.
module ram_dp_core
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_p1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // p0 -> p1: array write and registered read
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata_p1 <= mem[raddr];
    end

endmodule

// File: rtl/ram_dp_clr.sv
// Dual-port RAM with zero-fill sweep after reset or on Clear.
// Optional write-first forwarding: define RAM_DP_CLR_BYPASS_EN.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Write,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Read,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] DataOut,
    output logic              RdValid,
    input  logic              Clear,
    output logic              Ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    ram_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready_q;
    logic              rd_vld_p1;
    logic              zero_p1;
    logic              wr_ok;
    logic              rd_acc;
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata_p1;

    // Clear takes priority over a same-cycle access; the access is dropped.
    assign wr_ok  = (state == S_READY) && Write && !Clear && in_range(WrAddr);
    assign rd_acc = (state == S_READY) && Read && !Clear;

    assign core_we    = (state == S_CLEAR) || wr_ok;
    assign core_waddr = (state == S_CLEAR) ? clr_addr : WrAddr;
    assign core_wdata = (state == S_CLEAR) ? '0 : DataIn;

    ram_dp_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk      (clk),
        .we       (core_we),
        .waddr    (core_waddr),
        .wdata    (core_wdata),
        .re       (rd_acc && in_range(RdAddr)),
        .raddr    (RdAddr),
        .rdata_p1 (core_rdata_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST_ADDR) begin
                        state   <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (Clear) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                        ready_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // p0 -> p1: read strobe and output select; zero_p1 also masks the
    // uninitialised core register until the first in-range read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= 1'b0;
            zero_p1   <= 1'b1;
        end else begin
            rd_vld_p1 <= rd_acc;
            if (rd_acc)
                zero_p1 <= !in_range(RdAddr);
        end
    end

`ifdef RAM_DP_CLR_BYPASS_EN
    logic              byp_p1;
    logic [DATA_W-1:0] byp_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            byp_p1 <= 1'b0;
        else if (rd_acc)
            byp_p1 <= wr_ok && (WrAddr == RdAddr);
    end

    always_ff @(posedge clk) begin
        if (rd_acc)
            byp_data_p1 <= DataIn;
    end

    assign DataOut = zero_p1 ? '0 : (byp_p1 ? byp_data_p1 : core_rdata_p1);
`else
    assign DataOut = zero_p1 ? '0 : core_rdata_p1;
`endif

    assign RdValid = rd_vld_p1;
    assign Ready   = ready_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Randomised bench for ram_dp_clr against a word-level reference model.
module tb_ram_dp_clr;

    localparam int AW = 5;
    localparam int DW = 3;
    localparam int D  = 32;
    localparam int D2 = 20;
`ifdef RAM_DP_CLR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          wr, rd, clr;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [DW-1:0] dout;
    logic          vld, rdy;

    logic          rst2_n = 1'b1;
    logic          wr2, rd2, clr2;
    logic [AW-1:0] wa2, ra2;
    logic [DW-1:0] wd2;
    logic [DW-1:0] dout2;
    logic          vld2, rdy2;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_mem [D];
    bit            m_ready;
    int            m_sweep;
    logic [DW-1:0] m_dout;
    bit            m_vld;

    ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .Write(wr), .WrAddr(wa), .DataIn(wd),
        .Read(rd), .RdAddr(ra), .DataOut(dout), .RdValid(vld),
        .Clear(clr), .Ready(rdy)
    );

    ram_dp_clr #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D2)) u_dut20 (
        .clk(clk), .rst_n(rst2_n), .Write(wr2), .WrAddr(wa2), .DataIn(wd2),
        .Read(rd2), .RdAddr(ra2), .DataOut(dout2), .RdValid(vld2),
        .Clear(clr2), .Ready(rdy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_sweep = 0;
        m_dout  = '0;
        m_vld   = 1'b0;
    endtask

    // Word-level behaviour of one rising edge, from the inputs held now.
    task automatic model_edge();
        if (!m_ready) begin
            m_mem[m_sweep] = '0;
            m_sweep++;
            m_vld = 1'b0;
            if (m_sweep == D) m_ready = 1'b1;
        end else if (clr) begin
            m_ready = 1'b0;
            m_sweep = 0;
            m_vld   = 1'b0;
        end else begin
            m_vld = rd;
            if (rd) begin
                if (int'(ra) < D) begin
                    m_dout = m_mem[ra];
                    if (BYP && wr && wa == ra) m_dout = wd;
                end else begin
                    m_dout = '0;
                end
            end
            if (wr && int'(wa) < D) m_mem[wa] = wd;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "/Ready"}, 32'(rdy), 32'(m_ready));
        check({tag, "/RdValid"}, 32'(vld), 32'(m_vld));
        check({tag, "/DataOut"}, 32'(dout), 32'(m_dout));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr = 1'b1; wa = a; wd = d;
        step("write");
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd = 1'b1; ra = a;
        step("read");
        rd = 1'b0;
        check("read_data", 32'(dout), 32'(exp));
        check("read_vld", 32'(vld), 32'd1);
        step("read_after");
        check("vld_pulse_end", 32'(vld), 32'd0);
        check("dout_hold", 32'(dout), 32'(exp));
    endtask

    task automatic step2();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr = 0; rd = 0; clr = 0; wa = '0; ra = '0; wd = '0;
        wr2 = 0; rd2 = 0; clr2 = 0; wa2 = '0; ra2 = '0; wd2 = '0;

        #3;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        model_reset();
        #1;
        check("rst_DataOut", 32'(dout), 32'd0);
        check("rst_RdValid", 32'(vld), 32'd0);
        check("rst_Ready", 32'(rdy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rst2_n = 1'b1;

        // Power-up sweep: Ready rises after exactly D edges, reads ignored.
        rd = 1'b1; ra = 5'd3;
        for (int i = 1; i <= D; i++) begin
            step("pwrup");
            check("pwrup_ready", 32'(rdy), 32'(i == D));
        end
        rd = 1'b0;

        do_read(5'd0, 3'b000);
        do_read(5'd15, 3'b000);
        do_read(5'd31, 3'b000);

        do_write(5'd0, 3'b101);
        do_write(5'd1, 3'b110);
        do_write(5'd16, 3'b011);
        do_write(5'd31, 3'b111);
        do_read(5'd0, 3'b101);
        do_read(5'd1, 3'b110);
        do_read(5'd16, 3'b011);
        do_read(5'd31, 3'b111);

        // Same-address read and write in one cycle.
        do_write(5'd16, 3'b110);
        wr = 1'b1; wa = 5'd16; wd = 3'b011; rd = 1'b1; ra = 5'd16;
        step("collide");
        wr = 1'b0; rd = 1'b0;
        check("collide_data", 32'(dout), BYP ? 32'b011 : 32'b110);
        do_read(5'd16, 3'b011);

        // Clear with a simultaneous write: write dropped, sweep DEPTH edges.
        clr = 1'b1; wr = 1'b1; wa = 5'd0; wd = 3'b101;
        step("clear");
        clr = 1'b0; wr = 1'b0;
        check("clear_ready_drop", 32'(rdy), 32'd0);
        for (int i = 1; i <= D; i++) begin
            rd = 1'b1; ra = 5'($urandom_range(0, D - 1));
            wr = 1'($urandom_range(0, 1)); wa = ra; wd = 3'b111;
            step("sweep");
            check("sweep_ready", 32'(rdy), 32'(i == D));
            check("sweep_vld", 32'(vld), 32'd0);
        end
        rd = 1'b0; wr = 1'b0;
        do_read(5'd0, 3'b000);
        do_read(5'd31, 3'b000);

        // Randomised traffic with occasional Clear.
        for (int i = 0; i < 600; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, D - 1));
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, D - 1));
            wd  = 3'($urandom);
            clr = ($urandom_range(0, 79) == 0);
            step("rand");
        end
        wr = 0; rd = 0; clr = 0;
        for (int i = 0; i < D; i++) step("drain");

        // Reset in the middle of a sweep.
        do_write(5'd5, 3'b110);
        do_read(5'd5, 3'b110);
        clr = 1'b1;
        step("clear2");
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step("sweep2");
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_DataOut", 32'(dout), 32'd0);
        check("midrst_Ready", 32'(rdy), 32'd0);
        check("midrst_RdValid", 32'(vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= D; i++) begin
            step("resweep");
            check("resweep_ready", 32'(rdy), 32'(i == D));
        end
        do_read(5'd5, 3'b000);

        // DEPTH=20 instance: out-of-range write ignored, read returns 0.
        check("d20_ready", 32'(rdy2), 32'd1);
        wr2 = 1'b1; wa2 = 5'd19; wd2 = 3'b101;
        step2();
        wa2 = 5'd25; wd2 = 3'b111;
        step2();
        wr2 = 1'b0; rd2 = 1'b1; ra2 = 5'd19;
        step2();
        check("d20_rd19", 32'(dout2), 32'b101);
        check("d20_vld19", 32'(vld2), 32'd1);
        ra2 = 5'd25;
        step2();
        check("d20_rd25", 32'(dout2), 32'b000);
        check("d20_vld25", 32'(vld2), 32'd1);
        rd2 = 1'b0;
        step2();
        check("d20_vld_end", 32'(vld2), 32'd0);
        rd2 = 1'b1; ra2 = 5'd19;
        step2();
        rd2 = 1'b0;
        check("d20_rd19_again", 32'(dout2), 32'b101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
